serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands. It latches operands on a start request and shifts one bit pair per cycle through the cell, holding the running carry in a flip-flop. It presents the WIDTH-bit sum and carry-out with a busy/done handshake. It is the area-minimal alternative to a ripple array of full adders, and sits between a requesting datapath and the shared adder cell.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled in the cycle start is accepted.
- b  input  WIDTH  operand B; sampled in the cycle start is accepted.
- cin  input  1  carry-in; sampled in the cycle start is accepted.
- busy  output  1  high while a serial addition is in progress (RUN).
- done  output  1  one-cycle pulse marking the cycle in which sum/cout become valid.
- s  output  WIDTH  sum result; holds its value until the next accepted start.
- cout  output  1  final carry-out; holds its value until the next accepted start.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads shift registers sa<=a and sb<=b, carry flop c<=cin, and bit counter cnt<=0.
  - The FSM then moves to RUN.
  - start=0 keeps the FSM in IDLE.
- RUN, once per cycle:
  - The cell computes {co, so} = sa[0] + sb[0] + c.
  - s_shift <= {so, s_shift[WIDTH-1:1]} (LSB-first result enters at the MSB and shifts right).
  - sa and sb shift right by 1, c <= co, cnt <= cnt+1.
  - When cnt == WIDTH-1 this is the final bit. At the clock edge s <= final shifted value, cout <= co, and the FSM moves to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 in this cycle is accepted as in IDLE, with direct entry to RUN (back-to-back operation).
  - Otherwise the FSM moves to IDLE.
- start is ignored while in RUN. Operands applied during RUN have no effect.
- Arithmetic: {cout, s} == a + b + cin exactly, modulo 2^(WIDTH+1). There is no saturation.
- cnt width is $clog2(WIDTH)+1 bits so that WIDTH=1 is legal. With WIDTH=1, RUN lasts exactly one cycle.
- busy is decoded from the state (busy = state==RUN). done = state==DONE. Neither is combinational from start.

## Timing
- Reset:
  - state=IDLE, busy=0, done=0, s=0, cout=0.
  - Internal sa, sb, s_shift, c and cnt are all 0.
- rst asserted mid-RUN: the operation is aborted at the next edge, all outputs return to reset values, and no done pulse is produced.
- rst and start high in the same cycle: rst wins.
- Latency:
  - start accepted at edge T gives busy=1 from T+1 through T+WIDTH.
  - done=1 and s/cout valid from T+WIDTH+1.
  - Total WIDTH+1 cycles from the accepting edge to done.
- Throughput: with start held high continuously, one result every WIDTH+1 cycles.
- s and cout change only at the RUN→DONE edge. They are stable throughout IDLE and the following RUN period, so a consumer may sample them any time after done.

## Structure
- Shared package serial_adder_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Counter-width helper function.
- Sub-module fa_cell: a one-bit full adder (inputs a, b, cin; outputs s, cout), built from two half adders plus an OR.
- The controller instantiates exactly one fa_cell. All sequencing lives in serial_adder_ctrl: FSM, shift registers, carry flop and counter.

## Test plan
- Reset then idle: hold rst 2 cycles → busy=0, done=0, s=0, cout=0. Outputs remain so for 10 idle cycles.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0, one-cycle start → busy high 8 cycles, done on cycle 9, s=8'h7F, cout=0.
- Overflow with carry-in: a=8'hFF, b=8'h01, cin=1 → s=8'h01, cout=1. Also a=8'hFF, b=8'hFF, cin=1 → s=8'hFF, cout=1.
- Start during busy: a second start with a=8'h00 at cycle 3 of RUN → ignored. The result still matches the first operands and there is only one done pulse.
- Back-to-back: start held high → done pulses every 9 cycles, and each result matches operands sampled at the accepting edge. Also: rst asserted at RUN cycle 4 → no done, outputs zero, and the next start completes normally.
- WIDTH=1 build: exhaustive 8 combinations of a, b, cin → {cout, s} equals the arithmetic sum, with done 2 cycles after start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder controller:
//   - state encoding constants and the FSM state type
//   - helper that sizes the bit counter for a given operand width
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // One extra bit over $clog2 so that a width of 1 still yields a
  // non-zero-width counter.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell
//   One-bit full adder built from two half adders and an OR gate.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  // first half adder: a + b
  assign h1_s = a ^ b;
  assign h1_c = a & b;

  // second half adder: partial sum + carry in
  assign s    = h1_s ^ cin;
  assign h2_c = h1_s & cin;

  // at most one of the half-adder carries can be set
  assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Adds two WIDTH-bit operands plus a carry-in by running a single
//   one-bit full-adder cell for WIDTH cycles, LSB first.
//
//   Handshake: start is a request that is only looked at while the
//   controller is not busy (IDLE or DONE); on the accepting edge a, b
//   and cin are captured. busy is high for the WIDTH cycles of the
//   serial pass. done is high for exactly one cycle, the first cycle in
//   which s/cout carry the new result. start seen during the done cycle
//   is accepted immediately, so a held start gives one result every
//   WIDTH+1 cycles. s/cout hold until the next result is written.
//
//   Ports:
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset
//     start : request pulse
//     a, b  : operands (WIDTH bits)
//     cin   : carry in
//     busy  : serial pass in progress
//     done  : one-cycle result-valid pulse
//     s     : sum (WIDTH bits), registered
//     cout  : final carry out, registered
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] s_shift;
  logic [WIDTH-1:0] s_shift_nx;
  logic [WIDTH-1:0] s_r;
  logic             c;
  logic             cout_r;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  // ---------------------------------------------------------------
  // The one shared adder cell
  // ---------------------------------------------------------------
  fa_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Result bits arrive LSB first: each new bit enters at the MSB and the
  // register shifts right, so after WIDTH steps bit 0 is in place.
  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign s_shift_nx = fa_s;
    end else begin : g_shift_wn
      assign s_shift_nx = {fa_s, s_shift[WIDTH-1:1]};
    end
  endgenerate

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        // back-to-back: a request here skips IDLE entirely
        state_nx = start ? RUN : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: operand shifters, carry flop, counter, result registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      s_shift <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      c   <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa      <= sa >> 1;
      sb      <= sb >> 1;
      c       <= fa_co;
      cnt     <= cnt + 1'b1;
      s_shift <= s_shift_nx;
      // The visible result only moves on the final step, so s/cout stay
      // stable through the whole next pass.
      if (last_bit) begin
        s_r    <= s_shift_nx;
        cout_r <= fa_co;
      end
    end
  end

  assign s    = s_r;
  assign cout = cout_r;

endmodule
